// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared types, word-index constants and frame-length helper
// for the CPU state dumper.
// Build option: define DUMP_CHECKSUM_EN to append a trailing XOR checksum
// word to every frame (frame grows by one word).
package cpu_dbg_pkg;

    // Dumper control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    // Values frozen at the moment a dump is requested
    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] stall;
        logic [31:0] flush;
        logic [31:0] pc;
    } snap_t;

    // Default upper half of the frame header word
    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hD5A7;

    // Word positions inside a frame
    localparam int IDX_HDR   = 0;
    localparam int IDX_CYC   = 1;
    localparam int IDX_STALL = 2;
    localparam int IDX_FLUSH = 3;
    localparam int IDX_PC    = 4;
    localparam int IDX_REG0  = 5;
    localparam int NUM_REGS  = 32;
    localparam int IDX_MEM0  = IDX_REG0 + NUM_REGS;

    // Total number of words in one frame for a given memory dump depth
    function automatic int frame_len(input int mem_words);
`ifdef DUMP_CHECKSUM_EN
        return IDX_MEM0 + mem_words + 1;
`else
        return IDX_MEM0 + mem_words;
`endif
    endfunction

endpackage

// File: rtl/dbg_event_counters.sv
// dbg_event_counters: free-running cycle / stall / flush counters for the
// CPU plus the snapshot latch that freezes them (and the PC) when a dump
// starts. All counters wrap naturally at 2^32.
module dbg_event_counters
    import cpu_dbg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        capture_i,
    input  logic [31:0] pc_i,
    output snap_t       snap_o
);

    logic [31:0] cyc_cnt_q,   cyc_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    snap_t       snap_q,      snap_d;

    // Counters only advance while the CPU is running
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (start_i) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (stall_i) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (flush_i) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    // Snapshot takes the counter values as they stand in the request cycle
    always_comb begin
        snap_d = snap_q;
        if (capture_i) begin
            snap_d.cyc   = cyc_cnt_q;
            snap_d.stall = stall_cnt_q;
            snap_d.flush = flush_cnt_q;
            snap_d.pc    = pc_i;
        end
    end

    // Counter and snapshot registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            snap_q      <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            snap_q      <= snap_d;
        end
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: on a dump request, streams a snapshot of CPU state
// (header, cycle/stall/flush counts, PC, R0..R31, first MEM_WORDS data
// memory words) as 32-bit words over a valid/ready stream.
// Build option: DUMP_CHECKSUM_EN appends the XOR of all prior frame words.
//
// Stream handshake: a word transfers on a rising edge where out_valid_o and
// out_ready_i are both high. Once out_valid_o is raised it stays high, and
// out_data_o stays unchanged, until that word transfers. The next word is
// loaded on the same edge as the transfer, so words can move every cycle.
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int          MEM_WORDS = 8,
    parameter logic [15:0] HDR_TAG   = HDR_TAG_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        snap_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        overrun_o,
    output dump_state_e dbg_state_o
);

    localparam int FRAME_LEN = frame_len(MEM_WORDS);
    localparam int MEM_END   = IDX_MEM0 + MEM_WORDS;
    // One spare code so MEM_END is representable even with no checksum word
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] I_HDR    = IDX_W'(IDX_HDR);
    localparam logic [IDX_W-1:0] I_CYC    = IDX_W'(IDX_CYC);
    localparam logic [IDX_W-1:0] I_STALL  = IDX_W'(IDX_STALL);
    localparam logic [IDX_W-1:0] I_FLUSH  = IDX_W'(IDX_FLUSH);
    localparam logic [IDX_W-1:0] I_PC     = IDX_W'(IDX_PC);
    localparam logic [IDX_W-1:0] I_REG0   = IDX_W'(IDX_REG0);
    localparam logic [IDX_W-1:0] I_MEM0   = IDX_W'(IDX_MEM0);
    localparam logic [IDX_W-1:0] I_MEMEND = IDX_W'(MEM_END);

    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      seq_q, seq_d;
    logic             overrun_q, overrun_d;

    logic             fire;
    logic             is_last;
    logic             capture;
    logic             ld_en;
    logic [IDX_W-1:0] ld_idx;
    logic [31:0]      word_sel;
    snap_t            snap;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0]      csum_q, csum_d;
`endif

    dbg_event_counters u_counters (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .capture_i (capture),
        .pc_i      (pc_i),
        .snap_o    (snap)
    );

    // Decide whether a word is loaded this cycle and which frame index it is
    always_comb begin
        fire    = out_valid_q && out_ready_i;
        is_last = (idx_q == LAST_IDX);
        capture = (state_q == IDLE) && snap_i;
        ld_en   = 1'b0;
        ld_idx  = '0;
        if (capture) begin
            ld_en  = 1'b1;
            ld_idx = I_HDR;
        end else if ((state_q == SEND) && fire && !is_last) begin
            ld_en  = 1'b1;
            ld_idx = idx_q + IDX_W'(1);
        end
    end

    // Read ports point at the word being loaded; idle at address 0 otherwise
    always_comb begin
        reg_addr_o = '0;
        mem_addr_o = '0;
        if (ld_en && (ld_idx >= I_REG0) && (ld_idx < I_MEM0)) begin
            reg_addr_o = 5'(ld_idx - I_REG0);
        end
        if (ld_en && (ld_idx >= I_MEM0) && (ld_idx < I_MEMEND)) begin
            mem_addr_o = 32'(ld_idx - I_MEM0) << 2;
        end
    end

    // Select the frame word for the index being loaded
    always_comb begin
        word_sel = '0;
        if (ld_idx == I_HDR) begin
            word_sel = {HDR_TAG, seq_q};
        end else if (ld_idx == I_CYC) begin
            word_sel = snap.cyc;
        end else if (ld_idx == I_STALL) begin
            word_sel = snap.stall;
        end else if (ld_idx == I_FLUSH) begin
            word_sel = snap.flush;
        end else if (ld_idx == I_PC) begin
            word_sel = snap.pc;
        end else if (ld_idx < I_MEM0) begin
            word_sel = reg_data_i;
        end else if (ld_idx < I_MEMEND) begin
            word_sel = mem_data_i;
        end
`ifdef DUMP_CHECKSUM_EN
        else begin
            // Word on the bus is transferring on this edge, fold it in too
            word_sel = csum_q ^ out_data_q;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snap_i) state_d = SEND;
            SEND:    if (fire && is_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state and registered datapath
    always_comb begin
        busy_o      = (state_q == SEND);
        out_valid_o = out_valid_q;
        out_data_o  = out_data_q;
        overrun_o   = overrun_q;
        dbg_state_o = state_q;
    end

    // Datapath next values: word load, frame end, sequence and overrun
    always_comb begin
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        seq_d       = seq_q;
        overrun_d   = overrun_q;
        if (ld_en) begin
            idx_d       = ld_idx;
            out_data_d  = word_sel;
            out_valid_d = 1'b1;
        end else if ((state_q == SEND) && fire && is_last) begin
            idx_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end
        if (state_q == DONE) begin
            seq_d = seq_q + 16'd1;
        end
        if (snap_i && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            seq_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            seq_q       <= seq_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of words already transferred in this frame
    always_comb begin
        csum_d = csum_q;
        if (capture) begin
            csum_d = '0;
        end else if (fire) begin
            csum_d = csum_q ^ out_data_q;
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule
